// File: rtl/accel_regs_pkg.sv
// Shared register map and bit positions for the accelerator command register bank.
// Offsets are word indices: byte offset = index * 4.
package accel_regs_pkg;

  localparam logic [5:0] REG_CTRL       = 6'h00;
  localparam logic [5:0] REG_STATUS     = 6'h01;
  localparam logic [5:0] REG_SRC        = 6'h02;
  localparam logic [5:0] REG_DST        = 6'h03;
  localparam logic [5:0] REG_LEN        = 6'h04;
  localparam logic [5:0] REG_DOORBELL   = 6'h05;
  localparam logic [5:0] REG_DONE_COUNT = 6'h06;
  localparam logic [5:0] REG_IRQ_STATUS = 6'h07;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_CNT_LSB = 8;

  localparam int IRQ_DONE = 0;
  localparam int IRQ_OVF  = 1;

  // A descriptor is {src, dst, len}, each DATA_WIDTH wide.
  localparam int DESC_WORDS = 3;

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through FIFO: dout_o shows the head whenever the FIFO is not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign dout_o  = empty_o ? '0 : mem_q[rdPtr_q];

  always_comb begin
    rdPtr_d = doPop  ? rdPtr_q + PtrW'(1) : rdPtr_q;
    wrPtr_d = doPush ? wrPtr_q + PtrW'(1) : wrPtr_q;
    count_d = count_q;
    if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
    else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= din_i;
  end

endmodule

// File: rtl/accel_cmd_regs.sv
// Register bank and command queue behind the AXI4-Lite set/get strobe interface.
// Doorbell writes queue {SRC,DST,LEN} descriptors for the accelerator datapath.
module accel_cmd_regs
  import accel_regs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CMD_DEPTH  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [DATA_WIDTH-1:0] set_data,
  input  logic                  set_stb,
  input  logic [ADDR_WIDTH-1:0] get_addr,
  output logic [DATA_WIDTH-1:0] get_data,
  input  logic                  get_stb,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] cmd_src,
  output logic [DATA_WIDTH-1:0] cmd_dst,
  output logic [DATA_WIDTH-1:0] cmd_len,
  input  logic                  done_stb,
  output logic                  irq
);

  localparam int DescW = DESC_WORDS * DATA_WIDTH;

  logic [1:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [DATA_WIDTH-1:0] doneCnt_q, doneCnt_d;
  logic [1:0]            irqSts_q, irqSts_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] getData_q, getData_d;

  logic                  setHit;
  logic [5:0]            setIdx;
  logic                  wrCtrl, wrSrc, wrDst, wrLen, wrDoorbell, wrDoneCnt, wrIrqSts;
  logic                  fifoFull, fifoEmpty, pop, pushReject;
  logic [CNT_WIDTH-1:0]  fifoCount;
  logic [DescW-1:0]      headDesc;
  logic                  unused_ok;

  assign unused_ok = ^{get_stb, set_addr[1:0], get_addr[1:0]};

  assign setHit     = set_stb && (set_addr[ADDR_WIDTH-1:8] == '0);
  assign setIdx     = set_addr[7:2];
  assign wrCtrl     = setHit && (setIdx == REG_CTRL);
  assign wrSrc      = setHit && (setIdx == REG_SRC);
  assign wrDst      = setHit && (setIdx == REG_DST);
  assign wrLen      = setHit && (setIdx == REG_LEN);
  assign wrDoorbell = setHit && (setIdx == REG_DOORBELL);
  assign wrDoneCnt  = setHit && (setIdx == REG_DONE_COUNT);
  assign wrIrqSts   = setHit && (setIdx == REG_IRQ_STATUS);

  assign cmd_valid  = !fifoEmpty;
  assign pop        = cmd_valid && cmd_ready;
  assign pushReject = wrDoorbell && fifoFull && !pop;

  cmd_fifo #(
    .WIDTH (DescW),
    .DEPTH (CMD_DEPTH),
    .CNT_W (CNT_WIDTH)
  ) u_cmd_fifo (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .push_i  (wrDoorbell),
    .pop_i   (pop),
    .din_i   ({src_q, dst_q, len_q}),
    .dout_o  (headDesc),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  assign {cmd_src, cmd_dst, cmd_len} = headDesc;

  // Sticky bits: a set in the same cycle as a W1C clear wins.
  always_comb begin
    ctrl_d = wrCtrl ? set_data[1:0] : ctrl_q;
    src_d  = wrSrc  ? set_data      : src_q;
    dst_d  = wrDst  ? set_data      : dst_q;
    len_d  = wrLen  ? set_data      : len_q;

    doneCnt_d = doneCnt_q;
    if (wrDoneCnt)     doneCnt_d = done_stb ? DATA_WIDTH'(1) : '0;
    else if (done_stb) doneCnt_d = doneCnt_q + DATA_WIDTH'(1);

    irqSts_d = irqSts_q & ~(wrIrqSts ? set_data[1:0] : 2'b00);
    if (done_stb)   irqSts_d[IRQ_DONE] = 1'b1;
    if (pushReject) irqSts_d[IRQ_OVF]  = 1'b1;

    irq_d = (irqSts_q[IRQ_DONE] & ctrl_q[IRQ_DONE]) |
            (irqSts_q[IRQ_OVF]  & ctrl_q[IRQ_OVF]);
  end

  always_comb begin
    getData_d = '0;
    if (get_addr[ADDR_WIDTH-1:8] == '0) begin
      case (get_addr[7:2])
        REG_CTRL:       getData_d[1:0] = ctrl_q;
        REG_STATUS: begin
          getData_d[STAT_BUSY]                   = cmd_valid;
          getData_d[STAT_FULL]                   = fifoFull;
          getData_d[STAT_EMPTY]                  = fifoEmpty;
          getData_d[STAT_CNT_LSB +: CNT_WIDTH]   = fifoCount;
        end
        REG_SRC:        getData_d = src_q;
        REG_DST:        getData_d = dst_q;
        REG_LEN:        getData_d = len_q;
        REG_DONE_COUNT: getData_d = doneCnt_q;
        REG_IRQ_STATUS: getData_d[1:0] = irqSts_q;
        default:        getData_d = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      doneCnt_q <= '0;
      irqSts_q  <= '0;
      irq_q     <= 1'b0;
      getData_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      doneCnt_q <= doneCnt_d;
      irqSts_q  <= irqSts_d;
      irq_q     <= irq_d;
      getData_q <= getData_d;
    end
  end

  assign get_data = getData_q;
  assign irq      = irq_q;

endmodule
